mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 43 ++++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the I-cache / D-cache memory arbiter:
//   - FSM state encoding (IDLE, GRANT_IC, GRANT_DC)
//   - owner encoding (IC = 0, DC = 1)
//   - transaction-type constants (read / write)
//   - default read burst length (words per cache line)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_GRANT_IC = 2'b01,
    ST_GRANT_DC = 2'b10
  } arb_state_e;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

  localparam logic TXN_READ  = 1'b0;
  localparam logic TXN_WRITE = 1'b1;

  localparam int BURST_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner select between the two cache ports.
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : on contention the port that was not the last owner wins
//   undefined : fixed priority, DC over IC (last-owner input ignored)
// Ports:
//   i_ic_req, i_dc_req : port is requesting (ren or wen)
//   i_last_owner       : owner of the previous grant (OWNER_IC / OWNER_DC)
//   o_win_valid        : at least one port is requesting
//   o_win_owner        : winning port
// -----------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_ic_req,
  input  logic i_dc_req,
  input  logic i_last_owner,
  output logic o_win_valid,
  output logic o_win_owner
);

  always_comb begin
    o_win_valid = i_ic_req | i_dc_req;
    o_win_owner = OWNER_IC;
    if (i_dc_req && !i_ic_req) begin
      o_win_owner = OWNER_DC;
    end else if (i_dc_req && i_ic_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      o_win_owner = (i_last_owner == OWNER_DC) ? OWNER_IC : OWNER_DC;
`else
      o_win_owner = OWNER_DC;
`endif
    end
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority never consults the previous owner.
  logic unused_last_owner;
  assign unused_last_owner = i_last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates the I-cache and D-cache ready/valid memory interfaces onto one
// word-granular memory port. A grant covers a whole BURST-beat line fill or a
// single write-through word, so cache transactions never interleave.
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick); when defined
// a last-owner register is built, otherwise DC has fixed priority.
// Ports:
//   i_clk, i_rst_n (async, active-low)
//   i_{ic,dc}_ren/wen/addr/wdata : cache requests
//   o_{ic,dc}_ready              : request beat accepted this cycle
//   o_{ic,dc}_valid/rdata        : read data returned to that cache
//   i_mem_ready, o_mem_addr/ren/wen/wdata, i_mem_rdata, i_mem_valid : memory
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BURST = BURST_DEFAULT,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ic_ren,
  input  logic          i_ic_wen,
  input  logic [AW-1:0] i_ic_addr,
  input  logic [DW-1:0] i_ic_wdata,
  output logic          o_ic_ready,
  output logic          o_ic_valid,
  output logic [DW-1:0] o_ic_rdata,
  input  logic          i_dc_ren,
  input  logic          i_dc_wen,
  input  logic [AW-1:0] i_dc_addr,
  input  logic [DW-1:0] i_dc_wdata,
  output logic          o_dc_ready,
  output logic          o_dc_valid,
  output logic [DW-1:0] o_dc_rdata,
  input  logic          i_mem_ready,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_ren,
  output logic          o_mem_wen,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_valid
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_CNT = CW'(BURST);
  localparam logic [CW-1:0] LAST_RET  = CW'(BURST - 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] returned_q, returned_d;
  logic          started_q, started_d;
  logic          txn_q, txn_d;
  logic          last_owner_q;
  logic          win_valid, win_owner;
  logic          granted;
  logic          sel_ren, sel_wen;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          fwd_ren, fwd_wen, beat_acc;

  mem_arb_pick u_pick (
    .i_ic_req     (i_ic_ren | i_ic_wen),
    .i_dc_req     (i_dc_ren | i_dc_wen),
    .i_last_owner (last_owner_q),
    .o_win_valid  (win_valid),
    .o_win_owner  (win_owner)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner_d;

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == ST_IDLE && win_valid) last_owner_d = win_owner;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) last_owner_q <= OWNER_IC;
    else          last_owner_q <= last_owner_d;
  end
`else
  assign last_owner_q = OWNER_IC;
`endif

  assign granted = (state_q != ST_IDLE);

  // Request source for the current owner.
  always_comb begin
    if (state_q == ST_GRANT_DC) begin
      sel_ren   = i_dc_ren;
      sel_wen   = i_dc_wen;
      sel_addr  = i_dc_addr;
      sel_wdata = i_dc_wdata;
    end else begin
      sel_ren   = i_ic_ren;
      sel_wen   = i_ic_wen;
      sel_addr  = i_ic_addr;
      sel_wdata = i_ic_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    started_d  = started_q;
    txn_d      = txn_q;
    fwd_ren    = 1'b0;
    fwd_wen    = 1'b0;
    beat_acc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        issued_d   = '0;
        returned_d = '0;
        started_d  = 1'b0;
        txn_d      = TXN_READ;
        if (win_valid) state_d = (win_owner == OWNER_DC) ? ST_GRANT_DC : ST_GRANT_IC;
      end
      ST_GRANT_IC, ST_GRANT_DC: begin
        // Once the type is latched, only further reads of an unfinished burst
        // are forwarded; anything else from the owner is held off.
        fwd_ren  = sel_ren && (!started_q || (txn_q == TXN_READ && issued_q != BURST_CNT));
        fwd_wen  = sel_wen && !started_q;
        beat_acc = (fwd_ren || fwd_wen) && i_mem_ready;
        if (beat_acc && !started_q) begin
          started_d = 1'b1;
          txn_d     = fwd_wen ? TXN_WRITE : TXN_READ;
        end
        if (beat_acc && fwd_ren) issued_d = issued_q + CW'(1);
        if (beat_acc && fwd_wen) state_d = ST_IDLE;
        // Only responses to this grant's reads count toward completion.
        if (i_mem_valid && started_q && txn_q == TXN_READ) begin
          returned_d = returned_q + CW'(1);
          if (returned_q == LAST_RET) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      issued_q   <= '0;
      returned_q <= '0;
      started_q  <= 1'b0;
      txn_q      <= TXN_READ;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      started_q  <= started_d;
      txn_q      <= txn_d;
    end
  end

  // Every output is qualified by the registered state, so an asynchronous
  // reset (state forced to IDLE) zeroes all of them immediately.
  assign o_mem_ren   = fwd_ren;
  assign o_mem_wen   = fwd_wen;
  assign o_mem_addr  = granted ? sel_addr  : '0;
  assign o_mem_wdata = granted ? sel_wdata : '0;

  assign o_ic_ready  = (state_q == ST_GRANT_IC) && beat_acc;
  assign o_dc_ready  = (state_q == ST_GRANT_DC) && beat_acc;
  assign o_ic_valid  = i_mem_valid && (state_q == ST_GRANT_IC);
  assign o_dc_valid  = i_mem_valid && (state_q == ST_GRANT_DC);
  assign o_ic_rdata  = granted ? i_mem_rdata : '0;
  assign o_dc_rdata  = granted ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural memory (fixed latency),
// simple cache-side request drivers and a beat/response monitor.
// Per-cycle phase: posedge+1 drivers/memory drive, +2 main stimulus,
// +3 memory samples acceptance, +4 monitor logs, +6 main checks.
// Honours MEM_ARB_ROUND_ROBIN_EN for the contention expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BURST = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          rst_n;
  logic          ic_ren, ic_wen, dc_ren, dc_wen;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [DW-1:0] ic_wdata, dc_wdata;
  logic          ic_ready, dc_ready, ic_valid, dc_valid;
  logic [DW-1:0] ic_rdata, dc_rdata;
  logic          mem_ready, mem_ren, mem_wen, mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // Request state per port: index 0 = IC, 1 = DC.
  logic        req_ren [2];
  logic        req_wen [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  int          req_left [2];
  bit          req_hold [2];
  bit          acc [2];

  assign ic_ren = req_ren[0];  assign ic_wen = req_wen[0];
  assign ic_addr = req_addr[0]; assign ic_wdata = req_wdata[0];
  assign dc_ren = req_ren[1];  assign dc_wen = req_wen[1];
  assign dc_addr = req_addr[1]; assign dc_wdata = req_wdata[1];

  mem_arbiter #(.BURST(BURST), .AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ic_ren(ic_ren), .i_ic_wen(ic_wen), .i_ic_addr(ic_addr), .i_ic_wdata(ic_wdata),
    .o_ic_ready(ic_ready), .o_ic_valid(ic_valid), .o_ic_rdata(ic_rdata),
    .i_dc_ren(dc_ren), .i_dc_wen(dc_wen), .i_dc_addr(dc_addr), .i_dc_wdata(dc_wdata),
    .o_dc_ready(dc_ready), .o_dc_valid(dc_valid), .o_dc_rdata(dc_rdata),
    .i_mem_ready(mem_ready), .o_mem_addr(mem_addr), .o_mem_ren(mem_ren),
    .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .i_mem_valid(mem_valid)
  );

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  // Logs filled by the monitor.
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  bit          beat_own[$];
  logic [31:0] ic_data[$];
  logic [31:0] dc_data[$];
  int          ic_vcnt, dc_vcnt;
  int          first_beat [2];
  int          last_valid [2];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete(); beat_own.delete();
    ic_data.delete(); dc_data.delete();
    ic_vcnt = 0; dc_vcnt = 0;
    first_beat[0] = -1; first_beat[1] = -1;
    last_valid[0] = -1; last_valid[1] = -1;
  endtask

  task automatic start_read(input int p, input logic [31:0] a, input bit hold);
    req_addr[p] = a; req_left[p] = BURST; req_hold[p] = hold;
    req_wen[p] = 1'b0; req_ren[p] = 1'b1;
  endtask

  task automatic start_write(input int p, input logic [31:0] a, input logic [31:0] d);
    req_addr[p] = a; req_wdata[p] = d; req_left[p] = 1; req_hold[p] = 1'b0;
    req_ren[p] = 1'b0; req_wen[p] = 1'b1;
  endtask

  // Cache-side drivers: advance after each accepted beat.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          if (req_wen[p]) begin
            req_wen[p] = 1'b0;
          end else begin
            req_left[p]--;
            if (req_left[p] > 0) req_addr[p] = req_addr[p] + 32'd4;
            else if (!req_hold[p]) req_ren[p] = 1'b0;
          end
        end
      end
    end
  end

  // Memory: a read accepted in cycle c returns in cycle c+LAT.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        mem_valid = 1'b1;
        mem_rdata = mem_word(pend_addr[0]);
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
      end else begin
        mem_valid = 1'b0;
        mem_rdata = '0;
      end
      #2;
      if (mem_ren && mem_ready) begin
        pend_addr.push_back(mem_addr);
        pend_due.push_back(cyc + LAT);
      end
    end
  end

  // Monitor: one line per memory transaction and per returned word.
  initial begin
    bit own;
    forever begin
      @(posedge clk); #4;
      acc[0] = ic_ready;
      acc[1] = dc_ready;
      if (mem_ready && (mem_ren || mem_wen)) begin
        own = dc_ready;
        beat_own.push_back(own);
        if (first_beat[own] < 0) first_beat[own] = cyc;
        if (mem_ren) begin
          rd_log.push_back(mem_addr);
          $display("[%0d] read  %s addr=%h", cyc, own ? "DC" : "IC", mem_addr);
        end else begin
          wr_addr_log.push_back(mem_addr);
          wr_data_log.push_back(mem_wdata);
          $display("[%0d] write %s addr=%h data=%h", cyc, own ? "DC" : "IC", mem_addr, mem_wdata);
        end
      end
      if (ic_valid) begin
        ic_data.push_back(ic_rdata); ic_vcnt++; last_valid[0] = cyc;
        $display("[%0d] rdata IC %h", cyc, ic_rdata);
      end
      if (dc_valid) begin
        dc_data.push_back(dc_rdata); dc_vcnt++; last_valid[1] = cyc;
        $display("[%0d] rdata DC %h", cyc, dc_rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    bit exp_first;
    bit last_owner_m;
    bit second;
    logic [31:0] base_f, base_s;

    rst_n = 1'b0;
    mem_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req_ren[p] = 1'b0; req_wen[p] = 1'b0; req_addr[p] = '0; req_wdata[p] = '0;
      req_left[p] = 0; req_hold[p] = 1'b0; acc[p] = 1'b0;
    end
    clear_logs();
    last_owner_m = OWNER_IC;

    // Reset state.
    repeat (3) tick();
    settle();
    check("rst_mem_ren", 32'(mem_ren), 32'd0);
    check("rst_dc_ready", 32'(dc_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    settle();
    check("idle_mem_addr", mem_addr, 32'd0);
    check("idle_ic_ready", 32'(ic_ready), 32'd0);

    // DC-only line fill at 0x100.
    tick();
    clear_logs();
    start_read(1, 32'h100, 1'b0);
    settle();
    check("t1_no_fwd_in_idle", 32'(mem_ren), 32'd0);
    tick(); settle();
    check("t1_fwd_ren", 32'(mem_ren), 32'd1);
    check("t1_fwd_addr", mem_addr, 32'h100);
    check("t1_dc_ready", 32'(dc_ready), 32'd1);
    check("t1_ic_ready", 32'(ic_ready), 32'd0);
    budget = 40;
    while (dc_vcnt < 4 && budget > 0) begin tick(); budget--; end
    repeat (3) tick();
    check("t1_dc_valids", 32'(dc_vcnt), 32'd4);
    check("t1_ic_valids", 32'(ic_vcnt), 32'd0);
    check("t1_reads", 32'(rd_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_addr%0d", i), rd_log[i], 32'h100 + 32'(4 * i));
      check($sformatf("t1_data%0d", i), dc_data[i], mem_word(32'h100 + 32'(4 * i)));
    end
    last_owner_m = OWNER_DC;

    // Contention round 1: both ports request a line fill in the same cycle.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_first = (last_owner_m == OWNER_DC) ? OWNER_IC : OWNER_DC;
`else
    exp_first = OWNER_DC;
`endif
    second = !exp_first;
    base_f = exp_first ? 32'h300 : 32'h200;
    base_s = exp_first ? 32'h200 : 32'h300;
    tick();
    clear_logs();
    start_read(0, 32'h200, 1'b0);
    start_read(1, 32'h300, 1'b0);
    budget = 80;
    while ((ic_vcnt + dc_vcnt) < 8 && budget > 0) begin tick(); budget--; end
    repeat (3) tick();
    check("t2_reads", 32'(rd_log.size()), 32'd8);
    check("t2_first_owner", 32'(beat_own[0]), 32'(exp_first));
    check("t2_second_owner", 32'(beat_own[4]), 32'(second));
    check("t2_first_addr0", rd_log[0], base_f);
    check("t2_first_addr3", rd_log[3], base_f + 32'hC);
    check("t2_second_addr0", rd_log[4], base_s);
    check("t2_ic_valids", 32'(ic_vcnt), 32'd4);
    check("t2_dc_valids", 32'(dc_vcnt), 32'd4);
    check("t2_regrant_gap", 32'(first_beat[second]), 32'(last_valid[exp_first] + 2));
    last_owner_m = second;

    // Contention rounds 2 and 3: simultaneous single-word writes.
    for (int r = 2; r <= 3; r++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_first = (last_owner_m == OWNER_DC) ? OWNER_IC : OWNER_DC;
`else
      exp_first = OWNER_DC;
`endif
      tick();
      clear_logs();
      start_write(0, 32'h80, 32'h1C00_0000 + 32'(r));
      start_write(1, 32'hC0, 32'hDC00_0000 + 32'(r));
      budget = 20;
      while (wr_addr_log.size() < 2 && budget > 0) begin tick(); budget--; end
      tick();
      check($sformatf("t2w%0d_writes", r), 32'(wr_addr_log.size()), 32'd2);
      check($sformatf("t2w%0d_first_owner", r), 32'(beat_own[0]), 32'(exp_first));
      check($sformatf("t2w%0d_first_data", r), wr_data_log[0],
            exp_first ? (32'hDC00_0000 + 32'(r)) : (32'h1C00_0000 + 32'(r)));
      last_owner_m = !exp_first;
    end

    // DC write while memory stalls for 3 cycles.
    tick();
    clear_logs();
    mem_ready = 1'b0;
    start_write(1, 32'h40, 32'hDEAD_BEEF);
    settle();
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check($sformatf("t3_stall_ready%0d", i), 32'(dc_ready), 32'd0);
    end
    check("t3_stall_wen", 32'(mem_wen), 32'd1);
    check("t3_stall_addr", mem_addr, 32'h40);
    tick();
    mem_ready = 1'b1;
    settle();
    check("t3_ready", 32'(dc_ready), 32'd1);
    check("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick(); settle();
    check("t3_idle_after_write", 32'(mem_wen), 32'd0);
    repeat (2) tick();
    check("t3_writes", 32'(wr_addr_log.size()), 32'd1);
    check("t3_write_addr", wr_addr_log[0], 32'h40);
    check("t3_write_data", wr_data_log[0], 32'hDEAD_BEEF);

    // IC keeps ren high after its 4 beats.
    tick();
    clear_logs();
    start_read(0, 32'h500, 1'b1);
    budget = 30;
    while (rd_log.size() < 4 && budget > 0) begin tick(); budget--; end
    settle();
    check("t4_no_5th_ren", 32'(mem_ren), 32'd0);
    check("t4_ic_ready_held", 32'(ic_ready), 32'd0);
    tick(); settle();
    check("t4_no_5th_ren_b", 32'(mem_ren), 32'd0);
    check("t4_ic_ready_held_b", 32'(ic_ready), 32'd0);
    req_ren[0] = 1'b0;
    repeat (4) tick();
    check("t4_reads", 32'(rd_log.size()), 32'd4);
    check("t4_ic_valids", 32'(ic_vcnt), 32'd4);

    // Reset mid-burst after two returns.
    tick();
    clear_logs();
    start_read(0, 32'h600, 1'b0);
    settle();
    budget = 40;
    while (ic_vcnt < 2 && budget > 0) begin tick(); settle(); budget--; end
    check("t5_two_returns", 32'(ic_vcnt), 32'd2);
    #2;
    rst_n = 1'b0;
    req_ren[0] = 1'b0; req_ren[1] = 1'b0; req_wen[0] = 1'b0; req_wen[1] = 1'b0;
    #1;
    check("t5_rst_ic_valid", 32'(ic_valid), 32'd0);
    check("t5_rst_ic_rdata", ic_rdata, 32'd0);
    check("t5_rst_mem_addr", mem_addr, 32'd0);
    check("t5_rst_mem_ren", 32'(mem_ren), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t5_late_valid_dropped", 32'(ic_vcnt), 32'd2);

    // Fresh request after reset.
    clear_logs();
    start_read(1, 32'h700, 1'b0);
    budget = 40;
    while (dc_vcnt < 4 && budget > 0) begin tick(); budget--; end
    repeat (2) tick();
    check("t5_post_reads", 32'(rd_log.size()), 32'd4);
    check("t5_post_addr0", rd_log[0], 32'h700);
    check("t5_post_data3", dc_data[3], mem_word(32'h70C));
    check("t5_post_ic_valids", 32'(ic_vcnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
